traffic_intersection_ctrl: RTL and testbench
============================================

TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 Parameter GREEN_TICKS, default 5, cycles each green phase lasts (>=1).
REQ-002 Parameter YELLOW_TICKS, default 3, cycles each yellow phase lasts (>=1).
REQ-003 Parameter ALLRED_TICKS, default 1, cycles each all-red clearance lasts (>=1).
REQ-004 Parameter PED_TICKS, default 4, cycles the pedestrian walk phase lasts (>=1).
REQ-005 Parameter FLASH_TICKS, default 2, half-period in cycles of the flash-mode blink (>=1).
REQ-006 Parameter TIMER_W, default 8, phase timer width; every *_TICKS SHALL be <= 2**TIMER_W.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-009 ped_req  input  1  pedestrian request; any cycle high latches a pending request.
REQ-010 flash_mode  input  1  level; high selects fault/night flashing operation.
REQ-011 ns_red, ns_yellow, ns_green  output  1 each  north-south lamps.
REQ-012 ew_red, ew_yellow, ew_green  output  1 each  east-west lamps.
REQ-013 ped_walk  output  1  walk signal, high only in PED_WALK.
REQ-014 ped_pending  output  1  latched request not yet served.
REQ-015 phase  output  3  current state code (below).

Function
REQ-016 States and codes SHALL be: ALL_RED=0, NS_GREEN=1, NS_YELLOW=2, EW_GREEN=3, EW_YELLOW=4, PED_WALK=5, FLASH=6.
REQ-017 Each timed state SHALL last exactly its *_TICKS cycles: timer loads TICKS-1 on entry, decrements each cycle, transition on the cycle timer==0.
REQ-018 Register next_dir (0=NS, 1=EW) SHALL select the green that follows clearance.
REQ-019 Transitions: NS_GREEN->NS_YELLOW->ALL_RED (next_dir<=1); EW_GREEN->EW_YELLOW->ALL_RED (next_dir<=0).
REQ-020 ALL_RED expiry: if ped_pending -> PED_WALK, else -> NS_GREEN when next_dir=0, EW_GREEN when next_dir=1.
REQ-021 PED_WALK expiry -> NS_GREEN or EW_GREEN per next_dir (no second clearance).
REQ-022 ped_pending SHALL set on ped_req, clear on the PED_WALK entry edge; set has priority over clear in the same cycle.
REQ-023 flash_mode high SHALL force FLASH at the next edge from any state, timer loaded FLASH_TICKS-1, blink bit cleared.
REQ-024 In FLASH: blink bit toggles on each timer expiry; ns_yellow=blink, ew_red=blink, all other lamps and ped_walk 0; ped_pending still latches.
REQ-025 flash_mode low while in FLASH SHALL exit to ALL_RED with next_dir=0, timer ALLRED_TICKS-1.
REQ-026 Lamps SHALL be Moore-decoded from state only: exactly one lamp per direction lit outside FLASH; red for the direction not green/yellow; both red in ALL_RED and PED_WALK.
REQ-027 Never SHALL ns_green/ns_yellow and ew_green/ew_yellow be high together.

Reset
REQ-028 rst_n low SHALL immediately give: state ALL_RED, timer ALLRED_TICKS-1, next_dir 0, ped_pending 0, blink 0; outputs ns_red=ew_red=1, all others 0, phase=0.
REQ-029 Reset mid-phase (any state, incl. FLASH) SHALL abandon the phase with no residual timer or request.
REQ-030 First edge after rst_n rises SHALL run normal ALL_RED timing.

Verification (GREEN=5, YELLOW=2, ALLRED=1, PED=3, FLASH=2)
REQ-031 Release reset, idle inputs -> phase sequence 0,1x5,2x2,0,3x5,4x2,0,1..., period 16 cycles, lamps per REQ-026.
REQ-032 ped_req 1-cycle pulse during NS_GREEN -> ped_pending=1 next cycle; after NS_YELLOW, ALL_RED(1), PED_WALK x3 with ped_walk=1, then EW_GREEN; ped_pending=0 from PED_WALK entry.
REQ-033 ped_req high on PED_WALK entry cycle -> ped_pending stays 1, walk served again at next ALL_RED.
REQ-034 flash_mode high during EW_GREEN -> FLASH next edge; ns_yellow/ew_red pattern 0,0,1,1,0,0...; drop flash_mode -> ALL_RED then NS_GREEN.
REQ-035 rst_n low asynchronously mid NS_YELLOW with ped_pending=1 -> outputs reset values without clock edge; ped_pending=0.
REQ-036 Assertion across all runs: REQ-027 never violated; each phase length equals its parameter.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
// Four-way intersection controller: alternates north-south and east-west
// greens through yellow and all-red clearance, inserts a pedestrian walk
// after clearance when requested, and overrides everything with a blinking
// flash mode. The current state code is exported on `phase` for observation.
module traffic_intersection_ctrl #(
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int PED_TICKS    = 4,
    parameter int FLASH_TICKS  = 2,
    parameter int TIMER_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5,
        FLASH     = 3'd6
    } state_e;

    // Timer reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [TIMER_W-1:0] GREEN_LOAD  = TIMER_W'(GREEN_TICKS - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LOAD = TIMER_W'(YELLOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LOAD = TIMER_W'(ALLRED_TICKS - 1);
    localparam logic [TIMER_W-1:0] PED_LOAD    = TIMER_W'(PED_TICKS - 1);
    localparam logic [TIMER_W-1:0] FLASH_LOAD  = TIMER_W'(FLASH_TICKS - 1);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 next_dir_q, next_dir_d;   // 0 = NS next, 1 = EW next
    logic                 pending_q, pending_d;
    logic                 blink_q, blink_d;
    logic                 timer_done;
    logic                 walk_entry;

    assign timer_done = (timer_q == '0);

    // State register: reset abandons any phase and any latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ALL_RED;
            timer_q    <= ALLRED_LOAD;
            next_dir_q <= 1'b0;
            pending_q  <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            next_dir_q <= next_dir_d;
            pending_q  <= pending_d;
            blink_q    <= blink_d;
        end
    end

    // Next-state logic: flash override first, then phase sequencing on expiry.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        next_dir_d = next_dir_q;
        blink_d    = blink_q;
        if (flash_mode && (state_q != FLASH)) begin
            state_d = FLASH;
            timer_d = FLASH_LOAD;
            blink_d = 1'b0;
        end else begin
            if (!timer_done) begin
                timer_d = timer_q - TIMER_W'(1);
            end
            case (state_q)
                ALL_RED: if (timer_done) begin
                    if (pending_q) begin
                        state_d = PED_WALK;
                        timer_d = PED_LOAD;
                    end else begin
                        state_d = next_dir_q ? EW_GREEN : NS_GREEN;
                        timer_d = GREEN_LOAD;
                    end
                end
                NS_GREEN: if (timer_done) begin
                    state_d = NS_YELLOW;
                    timer_d = YELLOW_LOAD;
                end
                NS_YELLOW: if (timer_done) begin
                    state_d    = ALL_RED;
                    timer_d    = ALLRED_LOAD;
                    next_dir_d = 1'b1;
                end
                EW_GREEN: if (timer_done) begin
                    state_d = EW_YELLOW;
                    timer_d = YELLOW_LOAD;
                end
                EW_YELLOW: if (timer_done) begin
                    state_d    = ALL_RED;
                    timer_d    = ALLRED_LOAD;
                    next_dir_d = 1'b0;
                end
                // Walk already followed a clearance, so go straight to green.
                PED_WALK: if (timer_done) begin
                    state_d = next_dir_q ? EW_GREEN : NS_GREEN;
                    timer_d = GREEN_LOAD;
                end
                FLASH: begin
                    if (!flash_mode) begin
                        state_d    = ALL_RED;
                        timer_d    = ALLRED_LOAD;
                        next_dir_d = 1'b0;
                        blink_d    = 1'b0;
                    end else if (timer_done) begin
                        timer_d = FLASH_LOAD;
                        blink_d = ~blink_q;
                    end
                end
                default: begin
                    state_d = ALL_RED;
                    timer_d = ALLRED_LOAD;
                end
            endcase
        end
    end

    // Pedestrian latch: a new request wins over the clear at walk entry.
    always_comb begin
        walk_entry = (state_d == PED_WALK) && (state_q != PED_WALK);
        pending_d  = ped_req | (pending_q & ~walk_entry);
    end

    // Lamp decode from state only, so a green never overlaps a cross green.
    always_comb begin
        ns_red    = 1'b0;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b0;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        ped_walk  = 1'b0;
        case (state_q)
            NS_GREEN:  begin ns_green  = 1'b1; ew_red = 1'b1; end
            NS_YELLOW: begin ns_yellow = 1'b1; ew_red = 1'b1; end
            EW_GREEN:  begin ew_green  = 1'b1; ns_red = 1'b1; end
            EW_YELLOW: begin ew_yellow = 1'b1; ns_red = 1'b1; end
            PED_WALK:  begin ns_red = 1'b1; ew_red = 1'b1; ped_walk = 1'b1; end
            FLASH:     begin ns_yellow = blink_q; ew_red = blink_q; end
            default:   begin ns_red = 1'b1; ew_red = 1'b1; end
        endcase
    end

    assign ped_pending = pending_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl with short phase timings.
module tb_traffic_intersection_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ped_req;
    logic       flash_mode;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       ped_walk, ped_pending;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    traffic_intersection_ctrl #(
        .GREEN_TICKS (5),
        .YELLOW_TICKS(2),
        .ALLRED_TICKS(1),
        .PED_TICKS   (3),
        .FLASH_TICKS (2),
        .TIMER_W     (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ped_req    (ped_req),
        .flash_mode (flash_mode),
        .ns_red     (ns_red),
        .ns_yellow  (ns_yellow),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_yellow  (ew_yellow),
        .ew_green   (ew_green),
        .ped_walk   (ped_walk),
        .ped_pending(ped_pending),
        .phase      (phase)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lamps {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} per phase code.
    function automatic logic [6:0] exp_lamps(input logic [2:0] ph, input logic blink);
        case (ph)
            3'd0:    return 7'b100_100_0;
            3'd1:    return 7'b001_100_0;
            3'd2:    return 7'b010_100_0;
            3'd3:    return 7'b100_001_0;
            3'd4:    return 7'b100_010_0;
            3'd5:    return 7'b100_100_1;
            3'd6:    return {1'b0, blink, 1'b0, blink, 3'b000};
            default: return 7'b000_000_0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [2:0] ph, input logic pend, input logic blink);
        logic [6:0] obs_l;
        logic [6:0] exp_l;
        obs_l = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};
        exp_l = exp_lamps(ph, blink);
        checks++;
        assert (phase === ph) else begin
            errors++;
            $error("FAIL %s phase: got %0d expected %0d", tag, phase, ph);
        end
        checks++;
        assert (obs_l === exp_l) else begin
            errors++;
            $error("FAIL %s lamps: got %b expected %b", tag, obs_l, exp_l);
        end
        checks++;
        assert (ped_pending === pend) else begin
            errors++;
            $error("FAIL %s ped_pending: got %b expected %b", tag, ped_pending, pend);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n consecutive cycles that must all show the same phase and pending value
    task automatic run_seq(input string tag, input logic [2:0] ph, input logic pend, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, ph, pend, 1'b0);
        end
    endtask

    // Conflicting greens/yellows must never be lit together.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert (!((ns_green | ns_yellow) && (ew_green | ew_yellow))) else begin
                errors++;
                $error("FAIL conflict: ns_g=%b ns_y=%b ew_g=%b ew_y=%b expected no overlap",
                       ns_green, ns_yellow, ew_green, ew_yellow);
            end
        end
    end

    initial begin
        logic blink_exp [5];
        blink_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rst_n      = 1'b0;
        ped_req    = 1'b0;
        flash_mode = 1'b0;

        // reset state
        #1;
        chk("reset_async", 3'd0, 1'b0, 1'b0);
        step();
        step();
        chk("reset_held", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_release", 3'd0, 1'b0, 1'b0);

        // idle cycle: 1x5, 2x2, 0, 3x5, 4x2, 0
        run_seq("idle_ns_green",  3'd1, 1'b0, 5);
        run_seq("idle_ns_yellow", 3'd2, 1'b0, 2);
        run_seq("idle_allred_a",  3'd0, 1'b0, 1);
        run_seq("idle_ew_green",  3'd3, 1'b0, 5);
        run_seq("idle_ew_yellow", 3'd4, 1'b0, 2);
        run_seq("idle_allred_b",  3'd0, 1'b0, 1);

        // pedestrian pulse during NS green
        run_seq("ped1_ns_green0", 3'd1, 1'b0, 1);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ped1_latched", 3'd1, 1'b1, 1'b0);
        run_seq("ped1_ns_green", 3'd1, 1'b1, 3);
        run_seq("ped1_ns_yellow", 3'd2, 1'b1, 2);
        run_seq("ped1_allred", 3'd0, 1'b1, 1);
        run_seq("ped1_walk", 3'd5, 1'b0, 3);
        run_seq("ped1_ew_green", 3'd3, 1'b0, 1);

        // flash from EW green: blink 0,0,1,1,0,0 then back via ALL_RED to NS green
        flash_mode = 1'b1;
        step();
        chk("flash_entry", 3'd6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("flash_blink", 3'd6, 1'b0, blink_exp[i]);
        end
        flash_mode = 1'b0;
        step();
        chk("flash_exit_allred", 3'd0, 1'b0, 1'b0);
        step();
        chk("flash_exit_ns_green", 3'd1, 1'b0, 1'b0);

        // request held high on the walk entry edge keeps pending set
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ped2_latched", 3'd1, 1'b1, 1'b0);
        run_seq("ped2_ns_green", 3'd1, 1'b1, 3);
        run_seq("ped2_ns_yellow", 3'd2, 1'b1, 2);
        run_seq("ped2_allred", 3'd0, 1'b1, 1);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ped2_walk_entry", 3'd5, 1'b1, 1'b0);
        run_seq("ped2_walk", 3'd5, 1'b1, 2);
        run_seq("ped2_ew_green", 3'd3, 1'b1, 5);
        run_seq("ped2_ew_yellow", 3'd4, 1'b1, 2);
        run_seq("ped2_allred2", 3'd0, 1'b1, 1);
        run_seq("ped2_walk2", 3'd5, 1'b0, 3);
        run_seq("ped2_ns_green2", 3'd1, 1'b0, 1);

        // asynchronous reset mid NS yellow with a pending request
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("rst_latched", 3'd1, 1'b1, 1'b0);
        run_seq("rst_ns_green", 3'd1, 1'b1, 3);
        run_seq("rst_ns_yellow", 3'd2, 1'b1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_yellow", 3'd0, 1'b0, 1'b0);
        step();
        chk("rst_mid_held", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_first_edge", 3'd1, 1'b0, 1'b0);
        run_seq("rst_ns_green2", 3'd1, 1'b0, 4);
        run_seq("rst_ns_yellow2", 3'd2, 1'b0, 2);

        // reset during flash
        flash_mode = 1'b1;
        step();
        chk("flash2_entry", 3'd6, 1'b0, 1'b0);
        #2;
        rst_n      = 1'b0;
        flash_mode = 1'b0;
        #1;
        chk("flash2_reset", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("flash2_after_reset", 3'd1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
